fifo_wr_arbiter: RTL and testbench

Shares the single write port of one sync_fifo among NUM_REQ producers. Arbitration is round-robin, with burst locking so that a multi-word transfer from one producer lands contiguously in the FIFO. Sits directly in front of the FIFO write side (wr_en/data_in/full); the read side is untouched. An idle timeout releases a stalled lock so other producers are not starved.

---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for one sync_fifo, with burst locking so a
// producer's multi-word transfer lands contiguously; idle timeout frees stalled locks.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          lock_valid,
  output logic [$clog2(NUM_REQ)-1:0]    lock_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  lock_id_q;
  logic            lock_valid_q;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;

  logic [IDW-1:0]  sel_idx, gnt_idx;
  logic            sel_vld, cand_vld, locked, lock_req, xfer, last_g;
  logic            beat_end, idle_end, rel;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + IDW'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    cand    = 0;
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!sel_vld && req[cand[IDW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[IDW-1:0];
      end
    end
  end

  assign locked   = (state_q == S_LOCKED);
  assign lock_req = req[lock_id_q];
  assign gnt_idx  = locked ? lock_id_q : sel_idx;
  assign cand_vld = locked ? lock_req : sel_vld;
  // rst gates the grant so nothing is written while reset is held.
  assign xfer     = cand_vld & ~fifo_full & ~rst;
  assign last_g   = last[gnt_idx];

  assign gnt          = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign fifo_wr_en   = xfer;
  assign fifo_data_in = xfer ? data_in[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign beat_cnt_d = beat_cnt_q + BCW'(1);
  assign idle_cnt_d = idle_cnt_q + ICW'(1);
  assign beat_end   = (beat_cnt_d == BCW'(MAX_BURST));
  assign idle_end   = (idle_cnt_d == ICW'(IDLE_TIMEOUT));
  assign rel        = locked & ((xfer & (last_g | beat_end)) | (~lock_req & idle_end));

  assign lock_valid = lock_valid_q;
  assign lock_id    = lock_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      lock_valid_q <= 1'b0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            if (last_g || MAX_BURST == 1) begin
              rr_ptr_q <= next_idx(gnt_idx);
            end else begin
              state_q      <= S_LOCKED;
              lock_valid_q <= 1'b1;
              lock_id_q    <= gnt_idx;
              beat_cnt_q   <= BCW'(1);
              idle_cnt_q   <= '0;
            end
          end
        end
        S_LOCKED: begin
          if (rel) begin
            state_q      <= S_IDLE;
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            rr_ptr_q     <= next_idx(lock_id_q);
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= '0;
          end else if (!lock_req) begin
            // Backpressure (req high, FIFO full) leaves both counters untouched.
            idle_cnt_q <= idle_cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table of per-cycle vectors plus hand sequences,
// with a scoreboard queue of expected FIFO words.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req, last, gnt;
  logic [NR*DW-1:0] data_in;
  logic            fifo_full, fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            lock_valid;
  logic [1:0]      lock_id;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4), .IDLE_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .lock_valid(lock_valid), .lock_id(lock_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] gnt;
    logic       lv;
    logic [1:0] lid;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  logic [5:0] seq[NR];
  int         n_chk, n_pass;

  function automatic vec_t mk(logic [3:0] r, logic [3:0] l, logic f,
                              logic [3:0] g, logic lv, logic [1:0] lid);
    vec_t v;
    v.req = r; v.last = l; v.full = f; v.gnt = g; v.lv = lv; v.lid = lid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f);
    req = r; last = l; fifo_full = f;
    for (int p = 0; p < NR; p++) data_in[p*DW +: DW] = {2'(p), seq[p]};
  endtask

  // Called at posedge+1; checks at negedge, returns at next posedge+1.
  task automatic apply(input vec_t v);
    logic [7:0] w;
    drive(v.req, v.last, v.full);
    for (int p = 0; p < NR; p++) if (v.gnt[p]) sb.push_back({2'(p), seq[p]});
    @(negedge clk);
    chk("gnt", gnt, v.gnt);
    chk("wr_en", fifo_wr_en, |v.gnt);
    chk("lock_valid", lock_valid, v.lv);
    chk("lock_id", lock_id, v.lid);
    if (fifo_wr_en) begin
      if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
      else begin
        w = sb.pop_front();
        chk("fifo_data", fifo_data_in, w);
      end
    end else begin
      chk("fifo_data_idle", fifo_data_in, 0);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) if (v.gnt[p]) seq[p]++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    for (int p = 0; p < NR; p++) seq[p] = '0;

    //            req      last     full  gnt      lv    lid
    // Plain round robin with every word a single-beat burst.
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0));
    // req0 three-word burst, req1 waiting.
    tbl.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0));
    // req2 long burst capped at 4 beats, req3 gets the next slot.
    tbl.push_back(mk(4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b1100, 4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2));
    // req1 burst with 5 cycles of FIFO full in the middle, ends on beat cap.
    tbl.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1));
    tbl.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1));
    tbl.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1));
    // Full in IDLE: no grant and the pointer stays at 2.
    tbl.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b0, 2'd0));

    // Reset held with all producers requesting.
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_lock_valid", lock_valid, 0);
    chk("rst_lock_id", lock_id, 0);
    chk("rst_data", fifo_data_in, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Idle timeout: req3 locks, then goes quiet for 16 cycles while req0 waits.
    apply(mk(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0));
    for (int k = 0; k < 16; k++)
      apply(mk(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3));
    apply(mk(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0));

    // Asynchronous reset in the middle of a req2 lock.
    apply(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0));
    drive(4'b0100, 4'b0000, 1'b0);
    #2;
    chk("pre_rst_gnt", gnt, 4'b0100);
    chk("pre_rst_lock_valid", lock_valid, 1);
    chk("pre_rst_lock_id", lock_id, 2);
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_wr_en", fifo_wr_en, 0);
    chk("async_rst_lock_valid", lock_valid, 0);
    chk("async_rst_lock_id", lock_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0));
    apply(mk(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0));

    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
